// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - nibble-serial W-bit add/subtract engine around one 4-bit ripple-carry adder.
// Optional signed-overflow output ovf is enabled by defining RCA_SEQ_OVF_EN.

module rca (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module rca_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   input  logic                   op_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
`ifdef RCA_SEQ_OVF_EN
   ,
   output logic                   ovf
`endif
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_reg, b_reg, result, result_nxt;
   logic          carry;
   logic [3:0]    nib_s;
   logic          nib_co;
   logic          last;

   assign last = (idx == IW'(NIBBLES - 1));

   rca u_rca (
      .a  (a_reg[4*idx +: 4]),
      .b  (b_reg[4*idx +: 4]),
      .ci (carry),
      .s  (nib_s),
      .co (nib_co)
   );

   // Working result with the current nibble merged in; becomes sum on the last nibble.
   always_comb begin
      result_nxt              = result;
      result_nxt[4*idx +: 4]  = nib_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         carry  <= 1'b0;
         result <= '0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg  <= a;
                  b_reg  <= op_sub ? ~b : b;
                  carry  <= op_sub ? 1'b1 : cin;
                  idx    <= '0;
                  result <= '0;
               end
            end
            RUN: begin
               result <= result_nxt;
               carry  <= nib_co;
               if (last) begin
                  sum  <= result_nxt;
                  cout <= nib_co;
`ifdef RCA_SEQ_OVF_EN
                  ovf  <= (a_reg[W-1] == b_reg[W-1]) && (result_nxt[W-1] != a_reg[W-1]);
`endif
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - self-checking bench for rca_seq_ctrl (vector table, random ops, corner sequences).

module tb_rca_seq_ctrl;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          op_sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef RCA_SEQ_OVF_EN
      ,
      .ovf       (ovf_s)
`endif
   );

`ifndef RCA_SEQ_OVF_EN
   assign ovf_s = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vcin;
      logic         vsub;
      logic [W-1:0] esum;
      logic         ecout;
      logic         eovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic on the operands as numbers.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin, input logic msub,
                        output logic [W-1:0] rs, output logic rc, output logic ro);
      longint ua, ub, ufull, sa, sb, sres;
      ua = longint'(ma);
      ub = longint'(mb);
      if (msub) ufull = ua + ((longint'(1) << W) - ub);
      else      ufull = ua + ub + longint'(mcin);
      rs = ufull[W-1:0];
      rc = ufull[W];
      sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
      sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
      sres = msub ? sa - sb : sa + sb + longint'(mcin);
      ro = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
   endtask

   // One full operation: accept, garbage inputs while busy, hold out_ready low, then handshake.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin, input logic tsub,
                         input int hold, output logic [W-1:0] rs, output logic rc, output logic ro);
      int n;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = ta; b = tb; cin = tcin; op_sub = tsub;
      @(posedge clk); #1;
      n = 1;
      while (!out_valid && n < 20) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom);
         cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(NIBBLES + 1));
      rs = sum; rc = cout; ro = ovf_s;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_sum", 32'(sum), 32'(rs));
         check("hold_cout", 32'(cout), 32'(rc));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
      check("post_hs_sum_held", 32'(sum), 32'(rs));
   endtask

   initial begin
      logic [W-1:0] rs, es;
      logic rc, ro, ec, eo;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};

      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, (i == 0) ? 3 : 1, rs, rc, ro);
         check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].esum));
         check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].ecout));
`ifdef RCA_SEQ_OVF_EN
         check($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].eovf));
`endif
      end

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic rcin, rsub;
         ra = W'($urandom); rb = W'($urandom);
         rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
         if (i % 8 == 0) ra = '1;
         model(ra, rb, rcin, rsub, es, ec, eo);
         run_op(ra, rb, rcin, rsub, $urandom_range(0, 2), rs, rc, ro);
         check("rand_sum", 32'(rs), 32'(es));
         check("rand_cout", 32'(rc), 32'(ec));
`ifdef RCA_SEQ_OVF_EN
         check("rand_ovf", 32'(ro), 32'(eo));
`endif
      end

      // Abort during the second RUN cycle; previous result is nonzero so clearing is visible.
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro);
      check("after_abort_sum", 32'(rs), 32'h0002);
      check("after_abort_cout", 32'(rc), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
